// File: rtl/pcie_tx_arb_pkg.sv
// Shared types and constants for the two-source PCIe TRN transmit arbiter.
package pcie_tx_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } arb_state_e;

    // trn_tbuf_av bit positions: posted (DMA writes) and completion (PIO reads)
    localparam int TBUF_P_BIT   = 1;
    localparam int TBUF_CPL_BIT = 2;

    localparam logic [63:0] IDLE_TD     = 64'h0;
    localparam logic [7:0]  IDLE_TREM_N = 8'hFF;

endpackage

// File: rtl/pcie_tx_arb_sel.sv
// Combinational grant selection: completions first, DMA once the completion burst limit is reached.
module pcie_tx_arb_sel
    import pcie_tx_arb_pkg::*;
#(
    parameter int MAX_CPL_BURST = 4,
    parameter int BURST_W       = 3
) (
    input  logic [1:0]         elig_i,
    input  logic [BURST_W-1:0] burst_cnt_i,
    output logic               gnt_o,
    output logic               vld_o
);

    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_CPL_BURST);

    logic burst_hit;

    assign burst_hit = (burst_cnt_i >= BURST_MAX);

    always_comb begin
        vld_o = |elig_i;
        gnt_o = 1'b0;
        if (elig_i == 2'b11) begin
            gnt_o = burst_hit;
        end else begin
            gnt_o = elig_i[1];
        end
    end

endmodule

// File: rtl/pcie_tx_arbiter.sv
// Arbitrates the endpoint TRN transmit port between the completion engine (r0) and FOFB DMA (r1).
// state   | meaning
// IDLE    | no owner; trn_* driven to idle values, both requesters held off
// GNT0    | completion engine owns trn_*, combinational pass-through
// GNT1    | DMA engine owns trn_*, combinational pass-through
module pcie_tx_arbiter
    import pcie_tx_arb_pkg::*;
#(
    parameter int MAX_CPL_BURST = 4,
    parameter int CNT_W         = 16
) (
    input  logic             trn_clk,
    input  logic             trn_reset_n,
    input  logic             trn_lnk_up_n,
    input  logic [63:0]      r0_td,
    input  logic [7:0]       r0_trem_n,
    input  logic             r0_tsof_n,
    input  logic             r0_teof_n,
    input  logic             r0_tsrc_rdy_n,
    output logic             r0_tdst_rdy_n,
    output logic             r0_dsc_n,
    input  logic [63:0]      r1_td,
    input  logic [7:0]       r1_trem_n,
    input  logic             r1_tsof_n,
    input  logic             r1_teof_n,
    input  logic             r1_tsrc_rdy_n,
    output logic             r1_tdst_rdy_n,
    output logic             r1_dsc_n,
    output logic [63:0]      trn_td,
    output logic [7:0]       trn_trem_n,
    output logic             trn_tsof_n,
    output logic             trn_teof_n,
    output logic             trn_tsrc_rdy_n,
    output logic             trn_tsrc_dsc_n,
    input  logic             trn_tdst_rdy_n,
    input  logic             trn_tdst_dsc_n,
    input  logic [3:0]       trn_tbuf_av,
    output logic [CNT_W-1:0] r0_tlp_cnt,
    output logic [CNT_W-1:0] r1_tlp_cnt
);

    localparam int BURST_W = $clog2(MAX_CPL_BURST + 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_CPL_BURST);

    arb_state_e         state_q, state_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [CNT_W-1:0]   r0_cnt_q, r0_cnt_d;
    logic [CNT_W-1:0]   r1_cnt_q, r1_cnt_d;
    logic [1:0]         elig;
    logic               sel_gnt, sel_vld;
    logic               owned, dsc, cpl, cpl0, cpl1;
    logic               unused_tbuf;

    assign elig[0] = ~r0_tsrc_rdy_n & ~r0_tsof_n & trn_tbuf_av[TBUF_CPL_BIT];
    assign elig[1] = ~r1_tsrc_rdy_n & ~r1_tsof_n & trn_tbuf_av[TBUF_P_BIT];
    assign unused_tbuf = trn_tbuf_av[0] ^ trn_tbuf_av[3];

    // Selection sees the post-update burst count so the limit takes effect on the completing beat.
    pcie_tx_arb_sel #(
        .MAX_CPL_BURST(MAX_CPL_BURST),
        .BURST_W      (BURST_W)
    ) u_sel (
        .elig_i     (elig),
        .burst_cnt_i(burst_d),
        .gnt_o      (sel_gnt),
        .vld_o      (sel_vld)
    );

    assign owned = (state_q != ST_IDLE);
    assign dsc   = owned & ~trn_tdst_dsc_n;
    assign cpl   = ~trn_tsrc_rdy_n & ~trn_tdst_rdy_n & ~trn_teof_n & ~dsc;
    assign cpl0  = cpl & (state_q == ST_GNT0);
    assign cpl1  = cpl & (state_q == ST_GNT1);

    assign trn_tsrc_dsc_n = 1'b1;
    assign r0_tlp_cnt     = r0_cnt_q;
    assign r1_tlp_cnt     = r1_cnt_q;

    always_comb begin
        trn_td         = IDLE_TD;
        trn_trem_n     = IDLE_TREM_N;
        trn_tsof_n     = 1'b1;
        trn_teof_n     = 1'b1;
        trn_tsrc_rdy_n = 1'b1;
        r0_tdst_rdy_n  = 1'b1;
        r1_tdst_rdy_n  = 1'b1;
        r0_dsc_n       = 1'b1;
        r1_dsc_n       = 1'b1;
        case (state_q)
            ST_GNT0: begin
                trn_td         = r0_td;
                trn_trem_n     = r0_trem_n;
                trn_tsof_n     = r0_tsof_n;
                trn_teof_n     = r0_teof_n;
                trn_tsrc_rdy_n = r0_tsrc_rdy_n;
                r0_tdst_rdy_n  = trn_tdst_rdy_n;
                r0_dsc_n       = trn_tdst_dsc_n;
            end
            ST_GNT1: begin
                trn_td         = r1_td;
                trn_trem_n     = r1_trem_n;
                trn_tsof_n     = r1_tsof_n;
                trn_teof_n     = r1_teof_n;
                trn_tsrc_rdy_n = r1_tsrc_rdy_n;
                r1_tdst_rdy_n  = trn_tdst_rdy_n;
                r1_dsc_n       = trn_tdst_dsc_n;
            end
            default: ;
        endcase
    end

    always_comb begin
        burst_d = burst_q;
        if (r1_tsrc_rdy_n || cpl1) begin
            burst_d = '0;
        end else if (cpl0 && (burst_q < BURST_MAX)) begin
            burst_d = burst_q + BURST_W'(1);
        end
    end

    always_comb begin
        r0_cnt_d = r0_cnt_q;
        r1_cnt_d = r1_cnt_q;
        if (cpl0) r0_cnt_d = r0_cnt_q + CNT_W'(1);
        if (cpl1) r1_cnt_d = r1_cnt_q + CNT_W'(1);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!trn_lnk_up_n && sel_vld) begin
                    state_d = sel_gnt ? ST_GNT1 : ST_GNT0;
                end
            end
            ST_GNT0, ST_GNT1: begin
                if (trn_lnk_up_n || dsc) begin
                    state_d = ST_IDLE;
                end else if (cpl) begin
                    if (sel_vld) state_d = sel_gnt ? ST_GNT1 : ST_GNT0;
                    else         state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge trn_clk) begin
        if (!trn_reset_n) begin
            state_q  <= ST_IDLE;
            burst_q  <= '0;
            r0_cnt_q <= '0;
            r1_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            burst_q  <= burst_d;
            r0_cnt_q <= r0_cnt_d;
            r1_cnt_q <= r1_cnt_d;
        end
    end

endmodule

// File: doc/pcie_tx_arbiter.md
# pcie_tx_arbiter

Shares the single 64-bit TRN transmit interface of the PCIe endpoint between two TLP sources: requester 0, the completion engine answering PIO reads of the FOFB register window, and requester 1, the FOFB DMA engine emitting memory-write TLPs of XY position data. Grants are made only at TLP boundaries and are gated on the core's per-class transmit buffer availability. Completions take priority, and a starvation guard keeps DMA moving. The block sits between the BMD transmit engines and the endpoint core's trn_t* ports.

## Interface

Parameters:
- MAX_CPL_BURST, default 4: consecutive requester-0 grants allowed while requester 1 waits.
- CNT_W, default 16: width of the per-requester TLP counters.

Ports:
- trn_clk, in, 1: core clock. All logic runs on this one clock.
- trn_reset_n, in, 1: reset, synchronous, active-low.
- trn_lnk_up_n, in, 1: link up, active-low.
- r0_td / r1_td, in, 64: requester data.
- r0_trem_n / r1_trem_n, in, 8: requester remainder.
- r0_tsof_n / r1_tsof_n, in, 1: requester start-of-frame.
- r0_teof_n / r1_teof_n, in, 1: requester end-of-frame.
- r0_tsrc_rdy_n / r1_tsrc_rdy_n, in, 1: requester source ready.
- r0_tdst_rdy_n / r1_tdst_rdy_n, out, 1: per-requester destination ready.
- r0_dsc_n / r1_dsc_n, out, 1: one-cycle abort pulse to the owning requester.
- trn_td, out, 64: data to the core.
- trn_trem_n, out, 8: remainder to the core.
- trn_tsof_n / trn_teof_n / trn_tsrc_rdy_n, out, 1 each: framing and source ready to the core.
- trn_tsrc_dsc_n, out, 1: tied to 1.
- trn_tdst_rdy_n, in, 1: core destination ready.
- trn_tdst_dsc_n, in, 1: core destination discontinue.
- trn_tbuf_av, in, 4: buffer availability. Bit 1 is posted, bit 2 is completion.
- r0_tlp_cnt / r1_tlp_cnt, out, CNT_W: completed-TLP counters.

## Operation

- States are IDLE, GNT0 and GNT1.
- A request is eligible when its tsrc_rdy_n=0, its tsof_n=0 and its buffer bit is set: r0 needs trn_tbuf_av[2], r1 needs trn_tbuf_av[1].
- Selection:
  - If only one requester is eligible, it is granted.
  - If both are eligible, r0 wins unless burst_cnt ≥ MAX_CPL_BURST, in which case r1 wins.
- burst_cnt:
  - Increments on each completed r0 TLP while r1 has tsrc_rdy_n=0, saturating at MAX_CPL_BURST.
  - Clears on any completed r1 TLP.
  - Clears when r1 deasserts tsrc_rdy_n.
- While in GNTx, trn_* mirrors rx_* combinationally and rx_tdst_rdy_n = trn_tdst_rdy_n. The non-granted requester sees tdst_rdy_n=1.
- In IDLE:
  - trn_tsrc_rdy_n=1, trn_tsof_n=1, trn_teof_n=1, trn_td=0, trn_trem_n=8'hFF.
  - Both rx_tdst_rdy_n=1.
- A TLP completes on a beat with granted teof_n=0, tsrc_rdy_n=0 and trn_tdst_rdy_n=0. On completion:
  - rx_tlp_cnt increments and wraps modulo 2^CNT_W.
  - The next state is chosen by re-running selection in the same cycle, giving back-to-back TLPs with no bubble. IDLE is entered if nothing is eligible.
- A sof_n=0 beat from a requester already mid-TLP is passed through unchanged. Framing correctness is the requester's responsibility.
- Discontinue: trn_tdst_dsc_n=0 while in GNTx pulses rx_dsc_n=0 for one cycle, the next state is IDLE, and the counter does not increment.
- Link down: trn_lnk_up_n=1 forces IDLE next cycle and blocks all grants. The owning requester gets no dsc pulse; it observes link-down itself.

## Timing

- Reset values: state=IDLE, burst_cnt=0, both counters=0, all *_n outputs=1, trn_td=0, trn_trem_n=8'hFF.
- A reset asserted mid-TLP returns to IDLE on the next edge. The truncated TLP is not counted.
- Grant latency: a request first seen eligible in IDLE at cycle N is granted (state GNTx) at N+1, and its first beat transfers at N+1 if trn_tdst_rdy_n=0.
- Back-to-back: an EOF handshake at cycle N, with the other requester (or the same one) eligible at N, gives the first beat of the next TLP at N+1.
- Buffer bits are sampled only at selection, never mid-TLP. A deassertion during a TLP does not interrupt it.
- Simultaneous EOF completion and trn_tdst_dsc_n=0: discontinue wins, giving a dsc pulse and no count.

## Structure

- Package pcie_tx_arb_pkg holds:
  - the state encoding;
  - TBUF_P_BIT=1 and TBUF_CPL_BIT=2;
  - the IDLE default constants for td and trem.
- Sub-module pcie_tx_arb_sel holds the purely combinational selection function. Inputs are the eligibility bits, burst_cnt and the MAX_CPL_BURST comparison; outputs are the grant and a valid flag. It is used at IDLE and at EOF completion.

## Test plan

- Single TLP: r1 sends a 3-beat TLP with tbuf_av=4'b0110 → granted the cycle after the request, 3 beats pass unchanged, r1_tlp_cnt=1, return to IDLE.
- Contention: both request continuously with 1-beat TLPs and MAX_CPL_BURST=4 → grant sequence 0,0,0,0,1,0,0,0,0,1 with no idle cycles.
- Buffer gating: trn_tbuf_av[2]=0 with only r0 requesting → no grant. Set bit 2 → grant the next cycle.
- Backpressure: trn_tdst_rdy_n=1 for 5 cycles mid-TLP → granted requester stalls, data held, no re-arbitration.
- Discontinue on beat 2 of 4 → r1_dsc_n low for exactly 1 cycle, state IDLE, counter unchanged.
- Reset and link-down: trn_reset_n=0, or trn_lnk_up_n=1, mid-TLP → IDLE next edge, all *_n outputs=1. Counters clear on reset only; link-down leaves them.
